// File: rtl/acq_pkg.sv
// rtl/acq_pkg.sv - shared types and state encodings for the acquisition trigger controller
package acq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_HOLDOFF   = 3'd1,
        ST_ARMED     = 3'd2,
        ST_CAPTURE   = 3'd3,
        ST_WAIT_SWAP = 3'd4
    } acq_state_e;

    typedef enum logic [1:0] {
        MODE_STOP   = 2'd0,
        MODE_NORMAL = 2'd1,
        MODE_AUTO   = 2'd2,
        MODE_SINGLE = 2'd3
    } acq_mode_e;

    typedef enum logic {
        SRC_CMP   = 1'b0,
        SRC_LEVEL = 1'b1
    } acq_src_e;

    typedef enum logic {
        EDGE_RISE = 1'b0,
        EDGE_FALL = 1'b1
    } acq_edge_e;

endpackage

// File: rtl/acq_trigger_ctrl_if.sv
// rtl/acq_trigger_ctrl_if.sv - ADC sample stream and capture-buffer handshake bundle
interface acq_trigger_ctrl_if #(
    parameter int ADW = 12
);
    logic           adc_ce;
    logic [ADW-1:0] adc_data;
    logic           cmp_in;
    logic           stable;
    logic           buf_full;
    logic           rd_busy;
    logic           cap_start;
    logic           cap_abort;
    logic           swap_req;

    modport master (
        output adc_ce, adc_data, cmp_in, stable, buf_full, rd_busy,
        input  cap_start, cap_abort, swap_req
    );

    modport slave (
        input  adc_ce, adc_data, cmp_in, stable, buf_full, rd_busy,
        output cap_start, cap_abort, swap_req
    );
endinterface

// File: rtl/acq_edge_det.sv
// rtl/acq_edge_det.sv - previous-sample registers and level/comparator edge detection
module acq_edge_det
    import acq_pkg::*;
#(
    parameter int ADW = 12
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           adc_ce,
    input  logic [ADW-1:0] adc_data,
    input  logic           cmp_in,
    input  logic           en,
    input  logic [ADW-1:0] level,
    input  acq_src_e       src,
    input  acq_edge_e      edg,
    output logic           trig
);

    logic [ADW-1:0] prev_data_q, prev_data_d;
    logic           prev_cmp_q, prev_cmp_d;
    logic           primed_q, primed_d;
    logic           lvl_rise, lvl_fall, cmp_rise, cmp_fall, hit;

    always_comb begin
        prev_data_d = prev_data_q;
        prev_cmp_d  = prev_cmp_q;
        if (adc_ce) begin
            prev_data_d = adc_data;
            prev_cmp_d  = cmp_in;
        end
        // primed drops whenever detection is disabled so the first strobe after arming only loads history
        primed_d = en && (primed_q || adc_ce);

        lvl_rise = (prev_data_q < level) && (adc_data >= level);
        lvl_fall = (prev_data_q > level) && (adc_data <= level);
        cmp_rise = !prev_cmp_q && cmp_in;
        cmp_fall = prev_cmp_q && !cmp_in;

        if (src == SRC_LEVEL) begin
            hit = (edg == EDGE_RISE) ? lvl_rise : lvl_fall;
        end else begin
            hit = (edg == EDGE_RISE) ? cmp_rise : cmp_fall;
        end
        trig = en && adc_ce && primed_q && hit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_data_q <= '0;
            prev_cmp_q  <= 1'b0;
            primed_q    <= 1'b0;
        end else begin
            prev_data_q <= prev_data_d;
            prev_cmp_q  <= prev_cmp_d;
            primed_q    <= primed_d;
        end
    end

endmodule

// File: rtl/acq_trigger_ctrl.sv
// rtl/acq_trigger_ctrl.sv - trigger/capture sequencer for ping-pong ADC acquisition buffers
module acq_trigger_ctrl
    import acq_pkg::*;
#(
    parameter int ADW = 12,
    parameter int HOW = 16,
    parameter int ATW = 24
) (
    input  logic                clk,
    input  logic                rst_n,
    acq_trigger_ctrl_if.slave   bus,
    input  logic [1:0]          mode,
    input  logic                src_sel,
    input  logic                edge_sel,
    input  logic [ADW-1:0]      level,
    input  logic [HOW-1:0]      holdoff,
    input  logic [ATW-1:0]      auto_to,
    input  logic                arm,
    input  logic                force_trig,
    output logic [2:0]          st,
    output logic                auto_fired,
    output logic [15:0]         trig_cnt
);

    acq_state_e     state_q, state_d;
    logic [HOW-1:0] ho_cnt_q, ho_cnt_d;
    logic [ATW-1:0] to_cnt_q, to_cnt_d;
    logic [ADW-1:0] lvl_q, lvl_d;
    acq_src_e       src_q, src_d;
    acq_edge_e      edg_q, edg_d;
    logic           auto_fired_q, auto_fired_d;
    logic [15:0]    trig_cnt_q, trig_cnt_d;
    logic           cap_start_q, cap_start_d;
    logic           cap_abort_q, cap_abort_d;
    logic           swap_req_q, swap_req_d;

    acq_mode_e      mode_e;
    logic           stop, abort, ho_done, auto_hit, edge_trig, fire;

    assign mode_e = acq_mode_e'(mode);
    assign stop   = (mode_e == MODE_STOP);
    assign abort  = stop || !bus.stable;

    acq_edge_det #(.ADW(ADW)) u_edge_det (
        .clk      (clk),
        .rst_n    (rst_n),
        .adc_ce   (bus.adc_ce),
        .adc_data (bus.adc_data),
        .cmp_in   (bus.cmp_in),
        .en       (state_q == ST_ARMED),
        .level    (lvl_q),
        .src      (src_q),
        .edg      (edg_q),
        .trig     (edge_trig)
    );

    always_comb begin
        ho_done  = (holdoff == '0) || (bus.adc_ce && ((ho_cnt_q + HOW'(1)) >= holdoff));
        auto_hit = (mode_e == MODE_AUTO) && (auto_to != '0) && bus.adc_ce
                   && ((to_cnt_q + ATW'(1)) >= auto_to);
        fire     = force_trig || edge_trig || auto_hit;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (arm && !stop && bus.stable) state_d = ST_ARMED;
            end
            ST_HOLDOFF: begin
                if (abort)        state_d = ST_IDLE;
                else if (ho_done) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                // buf_full has no meaning before capture starts, so it never outranks a trigger here
                if (abort)     state_d = ST_IDLE;
                else if (fire) state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (abort)             state_d = ST_IDLE;
                else if (bus.buf_full) state_d = ST_WAIT_SWAP;
            end
            ST_WAIT_SWAP: begin
                // a full buffer must be handed over before any abort can take effect
                if (!bus.rd_busy) begin
                    state_d = (stop || mode_e == MODE_SINGLE) ? ST_IDLE : ST_HOLDOFF;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cap_start_d = (state_q == ST_ARMED) && (state_d == ST_CAPTURE);
        cap_abort_d = (state_q == ST_CAPTURE) && (state_d == ST_IDLE);
        swap_req_d  = (state_q == ST_WAIT_SWAP) && (state_d != ST_WAIT_SWAP);
        trig_cnt_d  = trig_cnt_q + 16'(cap_start_d);

        auto_fired_d = auto_fired_q;
        if (cap_start_d) begin
            if (edge_trig)                    auto_fired_d = 1'b0;
            else if (!force_trig && auto_hit) auto_fired_d = 1'b1;
        end

        ho_cnt_d = '0;
        if (state_q == ST_HOLDOFF) ho_cnt_d = bus.adc_ce ? ho_cnt_q + HOW'(1) : ho_cnt_q;
        to_cnt_d = '0;
        if (state_q == ST_ARMED)   to_cnt_d = bus.adc_ce ? to_cnt_q + ATW'(1) : to_cnt_q;

        lvl_d = lvl_q;
        src_d = src_q;
        edg_d = edg_q;
        if (state_d == ST_ARMED && state_q != ST_ARMED) begin
            lvl_d = level;
            src_d = acq_src_e'(src_sel);
            edg_d = acq_edge_e'(edge_sel);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            ho_cnt_q     <= '0;
            to_cnt_q     <= '0;
            lvl_q        <= '0;
            src_q        <= SRC_CMP;
            edg_q        <= EDGE_RISE;
            auto_fired_q <= 1'b0;
            trig_cnt_q   <= '0;
            cap_start_q  <= 1'b0;
            cap_abort_q  <= 1'b0;
            swap_req_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ho_cnt_q     <= ho_cnt_d;
            to_cnt_q     <= to_cnt_d;
            lvl_q        <= lvl_d;
            src_q        <= src_d;
            edg_q        <= edg_d;
            auto_fired_q <= auto_fired_d;
            trig_cnt_q   <= trig_cnt_d;
            cap_start_q  <= cap_start_d;
            cap_abort_q  <= cap_abort_d;
            swap_req_q   <= swap_req_d;
        end
    end

    assign st            = state_q;
    assign auto_fired    = auto_fired_q;
    assign trig_cnt      = trig_cnt_q;
    assign bus.cap_start = cap_start_q;
    assign bus.cap_abort = cap_abort_q;
    assign bus.swap_req  = swap_req_q;

endmodule

// File: doc/acq_trigger_ctrl.md
ACQ_TRIGGER_CTRL -- requirements
Module: acq_trigger_ctrl

Interface
REQ-001 SHALL have param ADW, default 12, ADC sample width.
REQ-002 SHALL have param HOW, default 16, holdoff counter width; ATW, default 24, auto-timeout counter width.
REQ-003 clk  in  1  system clock; all logic rising-edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 adc_ce  in  1  one-clk sample strobe, one per ADC sample period.
REQ-006 adc_data  in  ADW  synchronized ADC sample, valid when adc_ce=1.
REQ-007 cmp_in  in  1  synchronized comparator square wave.
REQ-008 stable  in  1  signal-stable qualifier; low aborts acquisition.
REQ-009 buf_full  in  1  active write buffer full.
REQ-010 rd_busy  in  1  MCU readout in progress; blocks buffer swap.
REQ-011 mode  in  2  0=STOP, 1=NORMAL, 2=AUTO, 3=SINGLE.
REQ-012 src_sel  in  1  0=comparator edge, 1=ADC level crossing.
REQ-013 edge_sel  in  1  0=rising, 1=falling.
REQ-014 level  in  ADW  level-crossing threshold.
REQ-015 holdoff  in  HOW  post-capture holdoff, in adc_ce strobes.
REQ-016 auto_to  in  ATW  AUTO-mode timeout, in adc_ce strobes.
REQ-017 arm, force  in  1 each  one-clk pulses: arm acquisition / force trigger.
REQ-018 cap_start  out  1  one-clk pulse: start writing buffer.
REQ-019 cap_abort  out  1  one-clk pulse: discard partial capture.
REQ-020 swap_req  out  1  one-clk pulse: swap ping/pong buffers.
REQ-021 st  out  3  current state code; auto_fired  out  1; trig_cnt  out  16.

Function
REQ-022 States: IDLE, HOLDOFF, ARMED, CAPTURE, WAIT_SWAP.
REQ-023 IDLE -> ARMED on arm when mode!=STOP and stable=1; level/src_sel/edge_sel latched at ARMED entry.
REQ-024 Trigger evaluated only on adc_ce; previous-sample and previous-cmp registers update only on adc_ce.
REQ-025 Level rising: prev<level and cur>=level; falling: prev>level and cur<=level; unsigned compare, ADW bits.
REQ-026 Comparator: rising = cmp 0->1, falling = cmp 1->0, between consecutive strobes.
REQ-027 First strobe after ARMED entry only loads prev registers; no trigger possible on it.
REQ-028 ARMED -> CAPTURE on trigger or force; cap_start asserted the clk after the qualifying edge; trig_cnt +1, wraps at 16'hFFFF->0.
REQ-029 AUTO: ARMED counts strobes; count reaching auto_to fires trigger, sets auto_fired=1; real trigger clears auto_fired; auto_to=0 disables timeout.
REQ-030 CAPTURE -> WAIT_SWAP on buf_full.
REQ-031 WAIT_SWAP: swap_req pulses in first cycle with rd_busy=0; then SINGLE -> IDLE, else -> HOLDOFF.
REQ-032 HOLDOFF counts strobes to holdoff, then -> ARMED; holdoff=0 -> ARMED next clk.
REQ-033 stable=0 in ARMED/CAPTURE/HOLDOFF -> IDLE next clk; cap_abort pulses only if leaving CAPTURE.
REQ-034 mode=STOP in any state -> IDLE next clk, same abort rule; WAIT_SWAP stays until swap_req issued, then IDLE.
REQ-035 Priority same cycle: stable/STOP abort > buf_full > force > trigger > auto timeout.
REQ-036 arm outside IDLE ignored; force outside ARMED ignored.
REQ-037 cap_start, cap_abort, swap_req mutually exclusive, each max one clk wide.

Reset
REQ-038 Reset: state IDLE, all counters 0, all pulses 0, auto_fired 0, trig_cnt 0, prev registers 0.
REQ-039 Reset mid-CAPTURE: no cap_abort pulse; buffer owner resets on same rst_n.

Structure
REQ-040 Package acq_pkg: state enum, mode enum (STOP/NORMAL/AUTO/SINGLE), source enum, st encodings.
REQ-041 Sub-module acq_edge_det: prev registers, level/comparator edge detect, single trig pulse.

Verification
REQ-042 NORMAL, cmp src rising, holdoff=4: cmp 0->1 at strobe 10 -> cap_start next clk, trig_cnt=1; after buf_full+swap_req, no re-arm before 4 strobes.
REQ-043 Level src, level=0x800, falling: samples 0x900,0x800 -> trigger; samples 0x7FF,0x800 -> no trigger.
REQ-044 AUTO, auto_to=100, flat input -> cap_start after 100th strobe, auto_fired=1; following real edge clears it.
REQ-045 SINGLE: buf_full with rd_busy=1 for 50 clk -> swap_req at first rd_busy=0 clk, then IDLE; further edges ignored until arm.
REQ-046 stable drops mid-CAPTURE -> cap_abort one clk, IDLE; buf_full and force same cycle in ARMED -> force wins; STOP in HOLDOFF -> IDLE, no abort.
